// File: rtl/fetch_unit_if.sv
// Bundle of the fetch stage's control, instruction-memory and IF/ID signals.
// The master side is the fetch unit; the slave side is its environment.
interface fetch_unit_if;
  logic        i_stall;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_ack;
  logic [31:0] i_imem_rdata;
  logic [31:0] o_instr;
  logic [31:0] o_pc;
  logic        o_we;
  logic        o_flush;

  modport master (
    input  i_stall, i_redirect, i_redirect_pc, i_imem_ack, i_imem_rdata,
    output o_imem_req, o_imem_addr, o_instr, o_pc, o_we, o_flush
  );

  modport slave (
    output i_stall, i_redirect, i_redirect_pc, i_imem_ack, i_imem_rdata,
    input  o_imem_req, o_imem_addr, o_instr, o_pc, o_we, o_flush
  );
endinterface

// File: rtl/fetch_unit.sv
// MIPS instruction-fetch stage: owns the PC, issues one outstanding imem request,
// parks a stalled word in a hold buffer and squashes fetches on redirect.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               i_clk,
    input  logic               i_rst,
    fetch_unit_if.master       bus,
    output logic [1:0]         o_dbg_state
);

    // Memory handshake: o_imem_req stays high with o_imem_addr stable until a
    // cycle with i_imem_ack=1; that cycle completes the request and rdata is valid.
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DROP  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] redir_q, redir_d;
    logic [31:0] buf_instr_q, buf_instr_d;
    logic [31:0] buf_pc_q, buf_pc_d;
    logic [31:0] pc_plus4;
    logic        we_raw;

    assign pc_plus4    = pc_q + 32'd4;
    assign o_dbg_state = state_q;

    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        redir_d         = redir_q;
        buf_instr_d     = buf_instr_q;
        buf_pc_d        = buf_pc_q;
        we_raw          = 1'b0;
        bus.o_imem_req  = 1'b0;
        bus.o_imem_addr = 32'd0;
        bus.o_instr     = 32'd0;
        bus.o_pc        = 32'd0;

        if (!i_rst) begin
            unique case (state_q)
                FETCH: begin
                    bus.o_imem_req  = 1'b1;
                    bus.o_imem_addr = pc_q;
                    bus.o_instr     = bus.i_imem_rdata;
                    bus.o_pc        = pc_plus4;
                    if (bus.i_imem_ack) begin
                        if (bus.i_redirect) begin
                            pc_d = bus.i_redirect_pc;
                        end else if (!bus.i_stall) begin
                            we_raw = 1'b1;
                            pc_d   = pc_plus4;
                        end else begin
                            buf_instr_d = bus.i_imem_rdata;
                            buf_pc_d    = pc_plus4;
                            pc_d        = pc_plus4;
                            state_d     = HOLD;
                        end
                    end else if (bus.i_redirect) begin
                        // The request cannot be withdrawn; remember the target and
                        // throw away whatever the memory eventually returns.
                        redir_d = bus.i_redirect_pc;
                        state_d = DROP;
                    end
                end
                HOLD: begin
                    bus.o_instr = buf_instr_q;
                    bus.o_pc    = buf_pc_q;
                    if (bus.i_redirect) begin
                        pc_d    = bus.i_redirect_pc;
                        state_d = FETCH;
                    end else if (!bus.i_stall) begin
                        we_raw  = 1'b1;
                        state_d = FETCH;
                    end
                end
                DROP: begin
                    bus.o_imem_req  = 1'b1;
                    bus.o_imem_addr = pc_q;
                    if (bus.i_imem_ack) begin
                        pc_d    = bus.i_redirect ? bus.i_redirect_pc : redir_q;
                        state_d = FETCH;
                    end else if (bus.i_redirect) begin
                        redir_d = bus.i_redirect_pc;
                    end
                end
                default: begin
                    state_d = FETCH;
                end
            endcase
        end
    end

    assign bus.o_flush = bus.i_redirect & ~i_rst;
    assign bus.o_we    = we_raw & ~bus.i_redirect & ~i_rst;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= FETCH;
            pc_q        <= RESET_PC;
            redir_q     <= 32'd0;
            buf_instr_q <= 32'd0;
            buf_pc_q    <= 32'd0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            redir_q     <= redir_d;
            buf_instr_q <= buf_instr_d;
            buf_pc_q    <= buf_pc_d;
        end
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the pipelined MIPS core, sitting directly upstream of the IF/ID pipeline register. It owns the program counter and drives a single-outstanding-request instruction-memory handshake. It presents each fetched instruction with its PC+4 and a write-enable to the IF/ID register. It also absorbs decode stalls through a one-entry hold buffer and handles branch/jump redirects, squashing in-flight fetches.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
- i_clk  in  1  core clock; all state updates on rising edge
- i_rst  in  1  synchronous, active-high reset
- i_stall  in  1  decode hazard; IF/ID must not be written this cycle
- i_redirect  in  1  branch/jump taken in a later stage
- i_redirect_pc  in  32  target address, valid with i_redirect
- o_imem_req  out  1  instruction memory request
- o_imem_addr  out  32  request address; stable while o_imem_req is high and i_imem_ack is low
- i_imem_ack  in  1  memory completes the request; i_imem_rdata is valid this cycle
- i_imem_rdata  in  32  instruction word
- o_instr  out  32  instruction to IF/ID
- o_pc  out  32  fetch address + 4, to IF/ID
- o_we  out  1  IF/ID write enable
- o_flush  out  1  IF/ID clear; drives its next-PC reset input

## Operation
- Registers:
  - pc_q: fetch address
  - redir_q: pending redirect target
  - buf_instr, buf_pc: hold buffer
  - state: FETCH, HOLD or DROP
- Reset (i_rst high at an edge) sets pc_q=RESET_PC, state=FETCH, and redir_q, buf_instr and buf_pc to 0.
- While i_rst is high, o_imem_req, o_we and o_flush are 0, and o_instr and o_pc are 0.
- o_flush = i_redirect (combinational). o_we is forced 0 in any cycle with i_redirect=1.
- FETCH: o_imem_req=1, o_imem_addr=pc_q, o_instr=i_imem_rdata, o_pc=pc_q+4.
  - ack and redirect: discard data; pc_q<=i_redirect_pc; stay FETCH.
  - ack, no redirect, no stall: o_we=1; pc_q<=pc_q+4; stay FETCH.
  - ack, no redirect, stall: buf_instr<=rdata; buf_pc<=pc_q+4; pc_q<=pc_q+4; go to HOLD.
  - no ack, redirect: redir_q<=i_redirect_pc; go to DROP. The address is held until the ack arrives.
  - no ack, no redirect: no change.
- HOLD: o_imem_req=0, o_instr=buf_instr, o_pc=buf_pc.
  - redirect: discard buffer; pc_q<=i_redirect_pc; go to FETCH. Redirect takes priority over stall release.
  - no stall: o_we=1; go to FETCH.
  - stall: remain in HOLD.
- DROP: o_imem_req=1, o_imem_addr=pc_q (the stale address), o_we=0.
  - redirect: redir_q<=i_redirect_pc; the latest redirect wins.
  - ack: discard data; pc_q<=(i_redirect ? i_redirect_pc : redir_q); go to FETCH.
- pc arithmetic is 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0 with no flag.
- Every instruction appears on o_we exactly once, in address order, unless squashed by a redirect.

## Timing
- With a zero-wait memory (ack in the request cycle), throughput is 1 instruction per cycle.
- Request-to-o_we latency is 0 cycles from the ack. IF/ID captures data on the edge that ends the ack cycle.
- A stall on the ack cycle parks the word in HOLD. o_we rises in the first cycle with i_stall=0.
- While in HOLD there is no new request. Refetch starts the cycle after release, so there is a 1-cycle bubble.
- Redirect penalty:
  - In FETCH with an ack, or in HOLD: the target is requested on the next cycle.
  - In FETCH without an ack: the target is requested on the cycle after the pending ack (DROP).
- i_rst dominates everything, including mid-DROP or mid-HOLD. The first request to RESET_PC is issued in the first cycle after i_rst falls.

## Test plan
- **Reset and sequential fetch.** Reset, then zero-wait memory returning word=address. Required: o_imem_addr sequence 0,4,8,12 on consecutive cycles; o_we=1 each cycle; o_pc=4,8,12,16.
- **Stall on ack.** Ack at addr 8 with i_stall=1 for 3 cycles. Required: o_imem_req=0 for those 3 cycles; o_instr=word@8 and o_pc=12 held; o_we=1 in the release cycle. The next request is to addr 12.
- **Redirect with pending request.** Ack delay of 3 cycles at addr 16, with i_redirect=1 and target 32'h100 in the second cycle. Required:
  - o_flush=1 in that cycle.
  - o_imem_addr stays 16 until the ack.
  - The data is dropped and o_we is 0 throughout.
  - The next request is to 32'h100.
- **Redirect while in HOLD together with stall release.** Required: o_we=0, o_flush=1; the next request is to the redirect target; the buffered word never reaches IF/ID.
- **Two redirects during DROP.** Redirects to 32'h200, then 32'h300, before the ack. Required: the next fetch is to 32'h300.
- **Wrap and mid-operation reset.** Start with pc_q=32'hFFFF_FFFC. Required: o_pc=0, and the next address is 0. Assert i_rst during HOLD: all outputs are 0 and the first request after i_rst falls is to RESET_PC.
